// File: rtl/imm_gen.sv
// RV32I immediate generator: a zero-latency 12-bit sign extender for the ALU/load
// path, plus a registered full-format decoder for branch/jump/LUI/AUIPC logic.
module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     inst_code,
  output logic [XLEN-1:0] Imm_out,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  output logic [XLEN-1:0] imm_q,
  output logic [2:0]      imm_fmt_q,
  output logic            imm_valid_q
);

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Legacy path: no clock or reset involvement at all.
  assign Imm_out = {{(XLEN-12){inst_code[11]}}, inst_code};

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            sign;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_sh;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign sign   = instr[31];

  assign imm_i  = {{(XLEN-12){sign}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){sign}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{(XLEN-13){sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {{(XLEN-32){sign}}, instr[31:12], 12'b0};
  assign imm_j  = {{(XLEN-21){sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {{(XLEN-5){1'b0}}, instr[24:20]};

  logic [XLEN-1:0] imm_dec;
  fmt_e            fmt_dec;

  always_comb begin
    imm_dec = '0;
    fmt_dec = FMT_NONE;
    unique case (opcode)
      OP_IMM: begin
        // Shift-immediates carry shamt in [24:20]; the SRAI flag in [30] is not immediate data.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          imm_dec = imm_sh;
          fmt_dec = FMT_SHAMT;
        end else begin
          imm_dec = imm_i;
          fmt_dec = FMT_I;
        end
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        imm_dec = imm_i;
        fmt_dec = FMT_I;
      end
      OP_STORE: begin
        imm_dec = imm_s;
        fmt_dec = FMT_S;
      end
      OP_BRANCH: begin
        imm_dec = imm_b;
        fmt_dec = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        imm_dec = imm_u;
        fmt_dec = FMT_U;
      end
      OP_JAL: begin
        imm_dec = imm_j;
        fmt_dec = FMT_J;
      end
      default: begin
        imm_dec = '0;
        fmt_dec = FMT_NONE;
      end
    endcase
  end

  logic [XLEN-1:0] imm_d;
  logic [2:0]      imm_fmt_d;
  logic            imm_valid_d;

  // Invalid cycles hold the last decode so downstream can still read it.
  always_comb begin
    imm_d       = imm_q;
    imm_fmt_d   = imm_fmt_q;
    imm_valid_d = 1'b0;
    if (instr_valid) begin
      imm_d       = imm_dec;
      imm_fmt_d   = fmt_dec;
      imm_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imm_q       <= '0;
      imm_fmt_q   <= 3'd0;
      imm_valid_q <= 1'b0;
    end else begin
      imm_q       <= imm_d;
      imm_fmt_q   <= imm_fmt_d;
      imm_valid_q <= imm_valid_d;
    end
  end

endmodule

// File: tb/tb_imm_gen.sv
// Directed bench for imm_gen: combinational sign extension, per-format decode
// vectors, reset priority and hold behaviour.
module tb_imm_gen;

  logic        clk;
  logic        rst_n;
  logic [11:0] inst_code;
  logic [31:0] Imm_out;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] imm_q;
  logic [2:0]  imm_fmt_q;
  logic        imm_valid_q;

  int checks = 0;
  int errors = 0;

  imm_gen #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_code  (inst_code),
    .Imm_out    (Imm_out),
    .instr      (instr),
    .instr_valid(instr_valid),
    .imm_q      (imm_q),
    .imm_fmt_q  (imm_fmt_q),
    .imm_valid_q(imm_valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] exp_imm;
    logic [2:0]  exp_fmt;
    string       name;
  } dec_vec_t;

  typedef struct {
    logic [11:0] code;
    logic [31:0] exp;
  } sx_vec_t;

  dec_vec_t dvec[$];
  sx_vec_t  svec[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  task automatic check_regs(input string name, input logic [31:0] e_imm,
                            input logic [2:0] e_fmt, input logic e_vld);
    check({name, ".imm"}, imm_q, e_imm);
    check({name, ".fmt"}, {29'd0, imm_fmt_q}, {29'd0, e_fmt});
    check({name, ".vld"}, {31'd0, imm_valid_q}, {31'd0, e_vld});
  endtask

  // Drive one instruction at the falling edge, let it be captured, sample after.
  task automatic issue(input logic [31:0] ins, input logic vld);
    @(negedge clk);
    instr       = ins;
    instr_valid = vld;
    @(posedge clk);
    #1;
  endtask

  initial begin
    svec.push_back('{12'hDB6, 32'hFFFFFDB6});
    svec.push_back('{12'h5B6, 32'h000005B6});
    svec.push_back('{12'h800, 32'hFFFFF800});
    svec.push_back('{12'h7FF, 32'h000007FF});
    svec.push_back('{12'hFFF, 32'hFFFFFFFF});
    svec.push_back('{12'h000, 32'h00000000});

    dvec.push_back('{32'hFFF00093, 32'hFFFFFFFF, 3'd1, "addi_m1"});
    dvec.push_back('{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, "beq_m4"});
    dvec.push_back('{32'h123450B7, 32'h12345000, 3'd4, "lui"});
    dvec.push_back('{32'h0080006F, 32'h00000008, 3'd5, "jal_p8"});
    dvec.push_back('{32'h01F09093, 32'h0000001F, 3'd6, "slli31"});
    dvec.push_back('{32'h41F0D093, 32'h0000001F, 3'd6, "srai31"});
    dvec.push_back('{32'hFE112E23, 32'hFFFFFFFC, 3'd2, "sw_m4"});
    dvec.push_back('{32'h00000033, 32'h00000000, 3'd0, "add"});
    dvec.push_back('{32'h00412083, 32'h00000004, 3'd1, "lw_p4"});
    dvec.push_back('{32'h00008067, 32'h00000000, 3'd1, "jalr"});
    dvec.push_back('{32'h00000073, 32'h00000000, 3'd1, "ecall"});
    dvec.push_back('{32'hFFFFF097, 32'hFFFFF000, 3'd4, "auipc"});
    dvec.push_back('{32'h0000000F, 32'h00000000, 3'd0, "fence"});
    dvec.push_back('{32'h00000463, 32'h00000008, 3'd3, "beq_p8"});
    dvec.push_back('{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, "jal_m4"});
    dvec.push_back('{32'h7FF00013, 32'h000007FF, 3'd1, "addi_max"});
    dvec.push_back('{32'h0000007F, 32'h00000000, 3'd0, "illegal"});

    rst_n       = 1'b1;
    instr       = 32'h0;
    instr_valid = 1'b0;
    inst_code   = 12'h0;

    // Combinational path checked before the first clock edge, reset idle.
    foreach (svec[i]) begin
      inst_code = svec[i].code;
      #1;
      check($sformatf("sext_%03h", svec[i].code), Imm_out, svec[i].exp);
    end

    // Reset wins over a valid instruction on the same edge.
    @(negedge clk);
    rst_n       = 1'b0;
    instr       = 32'hFFF00093;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    check_regs("reset", 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n       = 1'b1;
    instr_valid = 1'b0;

    // Back-to-back table: one valid instruction every cycle.
    foreach (dvec[i]) begin
      issue(dvec[i].instr, 1'b1);
      check_regs(dvec[i].name, dvec[i].exp_imm, dvec[i].exp_fmt, 1'b1);
    end

    // Hold: after a J-type, three invalid cycles with garbage on instr.
    issue(32'h0080006F, 1'b1);
    check_regs("hold_load", 32'h00000008, 3'd5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      issue(32'hFFFFF097 ^ k, 1'b0);
      check_regs($sformatf("hold%0d", k), 32'h00000008, 3'd5, 1'b0);
    end

    // Mid-stream reset with a valid instruction present drops it.
    issue(32'hFE112E23, 1'b1);
    check_regs("pre_rst", 32'hFFFFFFFC, 3'd2, 1'b1);
    @(negedge clk);
    rst_n       = 1'b0;
    instr       = 32'h123450B7;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    check_regs("mid_rst", 32'h0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h01F09093, 1'b1);
    check_regs("post_rst", 32'h0000001F, 3'd6, 1'b1);

    // Legacy output unaffected by the registered path activity.
    inst_code = 12'h9A5;
    #1;
    check("sext_late", Imm_out, 32'hFFFFF9A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen.md
Name: imm_gen

Overview:
- Immediate generator for the RV32I single-cycle core.
- Combinational legacy path: sign-extends a 12-bit immediate field to 32 bits with zero latency. The datapath uses this for I-type ALU and load offsets.
- Registered decode path: extracts and sign-extends the immediate of any RV32I format from a full 32-bit instruction. The result is registered and used by the branch/jump target and LUI/AUIPC logic.

Parameters:
- XLEN, 32, output immediate width; only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- inst_code  input  12  raw 12-bit immediate field (instr[31:20]).
- Imm_out  output  32  combinational sign extension of inst_code.
- instr  input  32  full instruction word for the registered decode path.
- instr_valid  input  1  instr is valid this cycle.
- imm_q  output  32  registered decoded immediate.
- imm_fmt_q  output  3  registered format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 reserved/unused.
- imm_valid_q  output  1  registered copy of instr_valid.

Behaviour:
- Imm_out = {{20{inst_code[11]}}, inst_code}.
  - Purely combinational and independent of clk/rst_n; stays correct when clk and rst_n are left unconnected.
- Decode of instr, by opcode instr[6:0]:
  - I, opcodes 0000011, 0010011 (except shifts), 1100111, 1110011: sext(instr[31:20]); fmt 1.
  - SHAMT, opcode 0010011 with funct3 = 001 or 101: zero-extended instr[24:20]; fmt 6. instr[30] (SRAI flag) is ignored.
  - S, 0100011: sext({instr[31:25], instr[11:7]}); fmt 2.
  - B, 1100011: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); fmt 3.
  - U, 0110111 / 0010111: {instr[31:12], 12'b0}; fmt 4.
  - J, 1101111: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}); fmt 5.
  - Any other opcode (R-type, FENCE 0001111, illegal): immediate 0, fmt 0.
- Registered path, on rising clk:
  - rst_n = 0: imm_q = 0, imm_fmt_q = 0, imm_valid_q = 0. Reset has priority over instr_valid.
  - else if instr_valid = 1: imm_q and imm_fmt_q load the decode of instr; imm_valid_q = 1. This holds even for fmt 0 (imm_q = 0).
  - else: imm_valid_q = 0; imm_q and imm_fmt_q hold their previous values.
- Latency: Imm_out 0 cycles; imm_q 1 cycle.
- Reset asserted mid-stream clears all registered outputs at that edge. A valid instruction on the reset edge is dropped.
- Sign bit is always instr[31] (or inst_code[11]). Immediates are never zero-extended except SHAMT and U.
- No X propagation from unused instr bits. funct7 and other don't-care fields have no effect except funct3 on 0010011.

Test Plan:
- inst_code = 12'hDB6, then 12'h5B6 -> Imm_out = 32'hFFFFFDB6, then 32'h000005B6, in the same delta; clk/rst_n idle.
- rst_n = 0 across one edge with instr_valid = 1 and instr = 32'hFFF00093 -> imm_q = 0, imm_fmt_q = 0, imm_valid_q = 0.
- Back-to-back valid instr, one per cycle:
  - 32'hFFF00093 -> imm_q = FFFFFFFF, fmt 1.
  - 32'hFE000EE3 -> imm_q = FFFFFFFC, fmt 3.
  - 32'h123450B7 -> imm_q = 12345000, fmt 4.
  - 32'h0080006F -> imm_q = 00000008, fmt 5.
- Shift handling:
  - 32'h01F09093 (SLLI 31) -> imm_q = 0000001F, fmt 6.
  - 32'h41F0D093 (SRAI 31) -> imm_q = 0000001F, fmt 6.
- Store and non-immediate:
  - 32'hFE112E23 (SW, offset -4) -> imm_q = FFFFFFFC, fmt 2.
  - 32'h00000033 (ADD) -> imm_q = 0, fmt 0, imm_valid_q = 1.
- instr_valid = 0 for 3 cycles after a valid J-type -> imm_valid_q = 0; imm_q stays 00000008 and imm_fmt_q stays 5.
